data_ram_ctrl: RTL

Parametrised, byte-addressed data memory with a request/ready handshake, configurable wait states, and MIPS-style sized accesses: byte/half/word, signed/unsigned loads, byte-lane stores. Misaligned accesses are detected and flagged. It sits between the datapath's memory stage and the storage array, replacing the fixed 32-word, word-indexed, asynchronous-read data RAM.

---
 rtl/data_ram_pkg.sv | 20 ++
 rtl/data_ram_ctrl_if.sv | 29 ++
 rtl/data_ram_lane_align.sv | 53 +++++
 rtl/data_ram_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM controller.
//   SZ_*    : access size codes carried on the Size field
//   CNT_W   : width of the wait-state counter (WAIT_CYCLES range 0..15)
//   state_t : controller state encoding, also exported for debug
package data_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Memory-stage bus between the datapath (master) and the data RAM
// controller (slave).
//   Req/WE/Size/Unsigned/Address/DataIn : request, driven by master
//   DataOut/Ready/Busy/AddrErr          : response, driven by slave
// Handshake: Req is sampled only while Busy=0; an accepted request is
// answered by exactly one Ready pulse, with AddrErr valid in that same
// cycle. Req presented while Busy=1 is dropped, not queued.
interface data_ram_ctrl_if;
    logic        Req;
    logic        WE;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Ready;
    logic        Busy;
    logic        AddrErr;

    modport master (
        output Req, WE, Size, Unsigned, Address, DataIn,
        input  DataOut, Ready, Busy, AddrErr
    );

    modport slave (
        input  Req, WE, Size, Unsigned, Address, DataIn,
        output DataOut, Ready, Busy, AddrErr
    );
endinterface

// File: rtl/data_ram_lane_align.sv
// Combinational byte-lane steering for sized little-endian accesses.
//   size, zext, addr_lo : access size, zero-extend select, Address[1:0]
//   rdata, wdata        : raw storage word, right-justified store data
//   be                  : byte-enable mask (bit n = lane n = bits 8n+7:8n)
//   wword               : store data replicated onto its lanes
//   rext                : selected and extended load value
//   misalign            : reserved size or unaligned half/word
module data_ram_lane_align
    import data_ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rext,
    output logic        misalign
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be       = 4'b0000;
        wword    = wdata;
        rext     = '0;
        misalign = 1'b0;
        rbyte    = rdata[{addr_lo, 3'b000} +: 8];
        rhalf    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                rext  = zext ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rext     = zext ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
                rext     = rdata;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Byte-addressed data memory with request/ready handshake, optional wait
// states and MIPS-style sized loads/stores.
//   CLK, Reset : clock, synchronous active-high reset (memory is kept)
//   bus        : data_ram_ctrl_if slave port (request in, response out)
//   state_dbg  : current controller state
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 5,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] INIT_BASE   = 32'h8000_0000
) (
    input  logic            CLK,
    input  logic            Reset,
    data_ram_ctrl_if.slave  bus,
    output state_t          state_dbg
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    // Power-up image: word i holds INIT_BASE + i. Reset never reloads it.
    function automatic logic [WORDS*32-1:0] init_image();
        logic [WORDS*32-1:0] img;
        for (int i = 0; i < WORDS; i++) img[32*i +: 32] = INIT_BASE + 32'(i);
        return img;
    endfunction

    logic [WORDS-1:0][31:0] mem = init_image();

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       dout, dout_n;
    logic              err, err_n;
    logic              do_access;

    logic              l_we, l_zext;
    logic [1:0]        l_size;
    logic [AW-1:0]     l_addr;
    logic [31:0]       l_din;

    logic              cur_we, cur_zext;
    logic [1:0]        cur_size;
    logic [AW-1:0]     cur_addr;
    logic [31:0]       cur_din;
    logic [DEPTH_LOG2-1:0] cur_idx;

    logic [3:0]        be;
    logic [31:0]       wword, rext;
    logic              misalign;

    // Upper address bits only alias; they never select storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Address[31:AW];

    // In IDLE the accept edge acts on the live request (needed when
    // WAIT_CYCLES=0); afterwards the latched copy is used.
    always_comb begin
        if (state == IDLE) begin
            cur_we   = bus.WE;
            cur_zext = bus.Unsigned;
            cur_size = bus.Size;
            cur_addr = bus.Address[AW-1:0];
            cur_din  = bus.DataIn;
        end else begin
            cur_we   = l_we;
            cur_zext = l_zext;
            cur_size = l_size;
            cur_addr = l_addr;
            cur_din  = l_din;
        end
    end

    assign cur_idx = cur_addr[AW-1:2];

    data_ram_lane_align u_align (
        .size     (cur_size),
        .zext     (cur_zext),
        .addr_lo  (cur_addr[1:0]),
        .rdata    (mem[cur_idx]),
        .wdata    (cur_din),
        .be       (be),
        .wword    (wword),
        .rext     (rext),
        .misalign (misalign)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dout_n    = dout;
        err_n     = err;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Req) begin
                    err_n = misalign;
                    if (misalign) begin
                        dout_n  = '0;
                        state_n = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_n   = RESP;
                    end else begin
                        cnt_n   = WAIT_LOAD;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    do_access = 1'b1;
                    state_n   = RESP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (do_access && !cur_we) dout_n = rext;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            dout  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
            err   <= err_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && bus.Req) begin
            l_we   <= bus.WE;
            l_zext <= bus.Unsigned;
            l_size <= bus.Size;
            l_addr <= bus.Address[AW-1:0];
            l_din  <= bus.DataIn;
        end
    end

    // A store pending in WAIT is dropped if Reset lands on its commit edge.
    always_ff @(posedge CLK) begin
        if (do_access && cur_we && !Reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cur_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign bus.DataOut = dout;
    assign bus.Ready   = (state == RESP);
    assign bus.Busy    = (state != IDLE);
    assign bus.AddrErr = err & (state == RESP);
    assign state_dbg   = state;

endmodule
